// File: rtl/slot_lcd_pkg.sv
// Shared constants, state encodings and text tables for the slot-machine LCD driver.
package slot_lcd_pkg;

    localparam logic [7:0] FUNC_SET = 8'h38;
    localparam logic [7:0] DISP_ON  = 8'h0C;
    localparam logic [7:0] ENTRY    = 8'h06;
    localparam logic [7:0] CLEAR    = 8'h01;
    localparam logic [7:0] L1_ADDR  = 8'h80;
    localparam logic [7:0] L2_ADDR  = 8'hC0;

    typedef enum logic [2:0] {
        S_PWR  = 3'd0,
        S_INIT = 3'd1,
        S_L1   = 3'd2,
        S_L2   = 3'd3,
        S_IDLE = 3'd4
    } lcd_state_t;

    typedef enum logic [1:0] {
        PH_SETUP  = 2'd0,
        PH_STROBE = 2'd1,
        PH_HOLD   = 2'd2
    } wr_phase_t;

    localparam logic [1:0] MSG_COIN  = 2'd0;
    localparam logic [1:0] MSG_START = 2'd1;
    localparam logic [1:0] MSG_SPIN  = 2'd2;
    localparam logic [1:0] MSG_WIN   = 2'd3;

    localparam logic [127:0] TXT_COIN   = "  INSERT COIN   ";
    localparam logic [127:0] TXT_START  = "  PRESS START   ";
    localparam logic [127:0] TXT_SPIN   = "  SPINNING...   ";
    localparam logic [127:0] TXT_WIN    = "   JACKPOT!!    ";
    localparam logic [63:0]  TXT_CREDIT = "CREDIT: ";

    function automatic logic [127:0] msg_text(input logic [1:0] msg);
        case (msg)
            MSG_COIN:  return TXT_COIN;
            MSG_START: return TXT_START;
            MSG_SPIN:  return TXT_SPIN;
            MSG_WIN:   return TXT_WIN;
            default:   return TXT_COIN;
        endcase
    endfunction

    // Column 0 is the leftmost character, i.e. the most significant byte of the literal.
    function automatic logic [7:0] text_char(input logic [127:0] txt, input logic [3:0] col);
        return txt[8 * (15 - int'(col)) +: 8];
    endfunction

endpackage

// File: rtl/slot_lcd_text_rom.sv
// Combinational character generator: message line 1 and "CREDIT: dd" line 2.
module slot_lcd_text_rom
    import slot_lcd_pkg::*;
(
    input  logic [1:0] msg,
    input  logic       line,
    input  logic [3:0] col,
    input  logic [6:0] credit,
    output logic [7:0] chr
);

    logic [6:0] sat_s;
    logic [7:0] bcd_s;

    // Shift-and-add-3 conversion; input is already saturated so two digits suffice.
    function automatic logic [7:0] bin_to_bcd(input logic [6:0] v);
        logic [14:0] sh;
        sh = {8'd0, v};
        for (int i = 0; i < 7; i++) begin
            if (sh[10:7] >= 4'd5) sh[10:7] = sh[10:7] + 4'd3;
            if (sh[14:11] >= 4'd5) sh[14:11] = sh[14:11] + 4'd3;
            sh = sh << 1;
        end
        return sh[14:7];
    endfunction

    // Character selection for the requested line and column
    always_comb begin
        sat_s = (credit > 7'd99) ? 7'd99 : credit;
        bcd_s = bin_to_bcd(sat_s);
        chr   = 8'h20;
        if (!line) begin
            chr = text_char(msg_text(msg), col);
        end else begin
            case (col)
                4'd8:    chr = 8'h30 | {4'h0, bcd_s[7:4]};
                4'd9:    chr = 8'h30 | {4'h0, bcd_s[3:0]};
                default: begin
                    if (col < 4'd8) chr = TXT_CREDIT[8 * (7 - int'(col[2:0])) +: 8];
                    else            chr = 8'h20;
                end
            endcase
        end
    end

endmodule

// File: rtl/slot_lcd_driver.sv
// HD44780 text-LCD driver: power-up init, then full two-line redraw whenever the
// requested message or credit changes. All timing advances on prescaled ticks.
module slot_lcd_driver
    import slot_lcd_pkg::*;
#(
    parameter int TICK_DIV    = 50,
    parameter int PWR_TICKS   = 15000,
    parameter int CLEAR_TICKS = 2000,
    parameter int CMD_TICKS   = 50
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [1:0] MSG_SEL,
    input  logic [6:0] CREDIT,
    output logic       LCD_E,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic [7:0] LCD_DATA,
    output logic       BUSY
);

    localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);
    localparam logic [15:0] PWR_LAST  = 16'(PWR_TICKS - 1);
    localparam logic [15:0] CMD_LAST  = 16'(CMD_TICKS - 1);
    localparam logic [15:0] CLR_LAST  = 16'(CMD_TICKS + CLEAR_TICKS - 1);

    logic [15:0] tick_cnt_r;
    logic        tick_s;

    lcd_state_t  state_r, state_nxt_s;
    wr_phase_t   phase_r, phase_nxt_s;
    logic [15:0] wait_r, wait_nxt_s;
    logic [4:0]  idx_r, idx_nxt_s;
    logic [1:0]  snap_msg_r, snap_msg_nxt_s;
    logic [6:0]  snap_credit_r, snap_credit_nxt_s;
    logic        busy_r, busy_nxt_s;

    logic        lcd_e_r, lcd_rs_r;
    logic [7:0]  lcd_data_r;
    logic        e_nxt_s, rs_nxt_s;
    logic [7:0]  data_nxt_s;

    logic [15:0] hold_last_s;
    logic [4:0]  last_idx_s;
    logic [3:0]  rom_col_s;
    logic [7:0]  rom_chr_s;

    // Tick prescaler: one-cycle pulse every TICK_DIV clocks
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)         tick_cnt_r <= 16'd0;
        else if (tick_s) tick_cnt_r <= 16'd0;
        else             tick_cnt_r <= tick_cnt_r + 16'd1;
    end

    assign tick_s = (tick_cnt_r == TICK_LAST);

    // The clear command needs the long settle time; the current write sits in the output regs.
    assign hold_last_s = (!lcd_rs_r && (lcd_data_r == CLEAR)) ? CLR_LAST : CMD_LAST;
    assign last_idx_s  = (state_r == S_INIT) ? 5'd3 : 5'd16;

    // Sequencer state, snapshot and LCD pin registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r       <= S_PWR;
            phase_r       <= PH_SETUP;
            wait_r        <= 16'd0;
            idx_r         <= 5'd0;
            snap_msg_r    <= 2'd0;
            snap_credit_r <= 7'd0;
            busy_r        <= 1'b1;
            lcd_e_r       <= 1'b0;
            lcd_rs_r      <= 1'b0;
            lcd_data_r    <= 8'h00;
        end else begin
            state_r       <= state_nxt_s;
            phase_r       <= phase_nxt_s;
            wait_r        <= wait_nxt_s;
            idx_r         <= idx_nxt_s;
            snap_msg_r    <= snap_msg_nxt_s;
            snap_credit_r <= snap_credit_nxt_s;
            busy_r        <= busy_nxt_s;
            lcd_e_r       <= e_nxt_s;
            lcd_rs_r      <= rs_nxt_s;
            lcd_data_r    <= data_nxt_s;
        end
    end

    // Next-state logic: power wait, write phases and draw sequencing
    always_comb begin
        state_nxt_s       = state_r;
        phase_nxt_s       = phase_r;
        wait_nxt_s        = wait_r;
        idx_nxt_s         = idx_r;
        snap_msg_nxt_s    = snap_msg_r;
        snap_credit_nxt_s = snap_credit_r;
        busy_nxt_s        = busy_r;
        if (tick_s) begin
            case (state_r)
                S_PWR: begin
                    if (wait_r == PWR_LAST) begin
                        state_nxt_s = S_INIT;
                        phase_nxt_s = PH_SETUP;
                        wait_nxt_s  = 16'd0;
                        idx_nxt_s   = 5'd0;
                    end else begin
                        wait_nxt_s = wait_r + 16'd1;
                    end
                end
                S_INIT, S_L1, S_L2: begin
                    case (phase_r)
                        PH_SETUP:  phase_nxt_s = PH_STROBE;
                        PH_STROBE: begin
                            phase_nxt_s = PH_HOLD;
                            wait_nxt_s  = 16'd0;
                        end
                        PH_HOLD: begin
                            if (wait_r == hold_last_s) begin
                                phase_nxt_s = PH_SETUP;
                                wait_nxt_s  = 16'd0;
                                if (idx_r == last_idx_s) begin
                                    idx_nxt_s = 5'd0;
                                    case (state_r)
                                        S_INIT: begin
                                            state_nxt_s       = S_L1;
                                            snap_msg_nxt_s    = MSG_SEL;
                                            snap_credit_nxt_s = CREDIT;
                                        end
                                        S_L1:    state_nxt_s = S_L2;
                                        default: begin
                                            state_nxt_s = S_IDLE;
                                            busy_nxt_s  = 1'b0;
                                        end
                                    endcase
                                end else begin
                                    idx_nxt_s = idx_r + 5'd1;
                                end
                            end else begin
                                wait_nxt_s = wait_r + 16'd1;
                            end
                        end
                        default: phase_nxt_s = PH_SETUP;
                    endcase
                end
                S_IDLE: begin
                    if ({MSG_SEL, CREDIT} != {snap_msg_r, snap_credit_r}) begin
                        state_nxt_s       = S_L1;
                        phase_nxt_s       = PH_SETUP;
                        wait_nxt_s        = 16'd0;
                        idx_nxt_s         = 5'd0;
                        snap_msg_nxt_s    = MSG_SEL;
                        snap_credit_nxt_s = CREDIT;
                        busy_nxt_s        = 1'b1;
                    end else begin
                        busy_nxt_s = 1'b0;
                    end
                end
                default: begin
                    state_nxt_s = S_PWR;
                    phase_nxt_s = PH_SETUP;
                    wait_nxt_s  = 16'd0;
                    idx_nxt_s   = 5'd0;
                    busy_nxt_s  = 1'b1;
                end
            endcase
        end
    end

    assign rom_col_s = 4'(idx_nxt_s - 5'd1);

    slot_lcd_text_rom u_text_rom (
        .msg    (snap_msg_nxt_s),
        .line   (state_nxt_s == S_L2),
        .col    (rom_col_s),
        .credit (snap_credit_nxt_s),
        .chr    (rom_chr_s)
    );

    // Pin values for the upcoming cycle; RS/DATA only move when entering a new write's setup.
    always_comb begin
        rs_nxt_s   = lcd_rs_r;
        data_nxt_s = lcd_data_r;
        case (state_nxt_s)
            S_INIT: begin
                rs_nxt_s = 1'b0;
                case (idx_nxt_s[1:0])
                    2'd0:    data_nxt_s = FUNC_SET;
                    2'd1:    data_nxt_s = DISP_ON;
                    2'd2:    data_nxt_s = ENTRY;
                    default: data_nxt_s = CLEAR;
                endcase
            end
            S_L1, S_L2: begin
                if (idx_nxt_s == 5'd0) begin
                    rs_nxt_s   = 1'b0;
                    data_nxt_s = (state_nxt_s == S_L1) ? L1_ADDR : L2_ADDR;
                end else begin
                    rs_nxt_s   = 1'b1;
                    data_nxt_s = rom_chr_s;
                end
            end
            default: begin
                rs_nxt_s   = lcd_rs_r;
                data_nxt_s = lcd_data_r;
            end
        endcase
        if ((state_nxt_s inside {S_INIT, S_L1, S_L2}) && (phase_nxt_s == PH_STROBE)) e_nxt_s = 1'b1;
        else                                                                      e_nxt_s = 1'b0;
    end

    assign LCD_E    = lcd_e_r;
    assign LCD_RS   = lcd_rs_r;
    assign LCD_RW   = 1'b0;
    assign LCD_DATA = lcd_data_r;
    assign BUSY     = busy_r;

endmodule

// File: tb/tb_slot_lcd_driver.sv
// Self-checking bench for slot_lcd_driver: captures every E strobe and compares the
// written byte stream and its timing against a text-level model of the display.
module tb_slot_lcd_driver;

    localparam int TICK_DIV    = 1;
    localparam int PWR_TICKS   = 4;
    localparam int CLEAR_TICKS = 3;
    localparam int CMD_TICKS   = 1;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [1:0] MSG_SEL = 2'd0;
    logic [6:0] CREDIT = 7'd0;
    logic       LCD_E, LCD_RS, LCD_RW, BUSY;
    logic [7:0] LCD_DATA;

    int tests_run = 0;
    int tests_failed = 0;

    logic [8:0] mon_q[$];
    int         mon_cyc[$];
    logic [8:0] exp_q[$];
    int         cyc = 0;
    logic       e_prev = 1'b0;
    logic [8:0] held = 9'd0;
    bit         unstable = 1'b0;
    bit         rw_bad = 1'b0;
    int         cur_msg = 0;
    int         cur_cr = 0;

    string msg_txt[4] = '{"  INSERT COIN   ", "  PRESS START   ", "  SPINNING...   ", "   JACKPOT!!    "};

    slot_lcd_driver #(
        .TICK_DIV    (TICK_DIV),
        .PWR_TICKS   (PWR_TICKS),
        .CLEAR_TICKS (CLEAR_TICKS),
        .CMD_TICKS   (CMD_TICKS)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .MSG_SEL  (MSG_SEL),
        .CREDIT   (CREDIT),
        .LCD_E    (LCD_E),
        .LCD_RS   (LCD_RS),
        .LCD_RW   (LCD_RW),
        .LCD_DATA (LCD_DATA),
        .BUSY     (BUSY)
    );

    always #5 CLK = ~CLK;

    // Strobe monitor, sampled on the falling edge
    always @(negedge CLK) begin
        cyc = cyc + 1;
        if (LCD_RW !== 1'b0) rw_bad = 1'b1;
        if (LCD_E === 1'b1 && !e_prev) begin
            mon_q.push_back({LCD_RS, LCD_DATA});
            mon_cyc.push_back(cyc);
            held = {LCD_RS, LCD_DATA};
        end else if (LCD_E === 1'b1 && {LCD_RS, LCD_DATA} !== held) begin
            unstable = 1'b1;
        end
        e_prev = (LCD_E === 1'b1);
    end

    // Reference model: the bytes a correct driver writes
    task automatic model_init();
        exp_q.push_back({1'b0, 8'h38});
        exp_q.push_back({1'b0, 8'h0C});
        exp_q.push_back({1'b0, 8'h06});
        exp_q.push_back({1'b0, 8'h01});
    endtask

    task automatic model_draw(input int msg, input int cr);
        string l1;
        string l2;
        l1 = msg_txt[msg];
        l2 = $sformatf("CREDIT: %02d      ", (cr > 99) ? 99 : cr);
        exp_q.push_back({1'b0, 8'h80});
        for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, l1[i]});
        exp_q.push_back({1'b0, 8'hC0});
        for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, l2[i]});
    endtask

    task automatic clear_capture();
        mon_q.delete();
        mon_cyc.delete();
        exp_q.delete();
    endtask

    task automatic wait_idle(input int max_cyc, output bit ok);
        int stable;
        stable = 0;
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge CLK);
            #1;
            if (BUSY === 1'b0) stable++;
            else               stable = 0;
            if (stable >= 3) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        MSG_SEL = 2'd0;
        CREDIT = 7'd0;
        repeat (3) @(negedge CLK);
        #1;
        tests_run++; if (LCD_E !== 1'b0)     begin tests_failed++; $display("FAIL reset_e: got %b want 0", LCD_E); end
        tests_run++; if (LCD_RS !== 1'b0)    begin tests_failed++; $display("FAIL reset_rs: got %b want 0", LCD_RS); end
        tests_run++; if (LCD_RW !== 1'b0)    begin tests_failed++; $display("FAIL reset_rw: got %b want 0", LCD_RW); end
        tests_run++; if (LCD_DATA !== 8'h00) begin tests_failed++; $display("FAIL reset_data: got %h want 00", LCD_DATA); end
        tests_run++; if (BUSY !== 1'b1)      begin tests_failed++; $display("FAIL reset_busy: got %b want 1", BUSY); end
    endtask

    // Runs from reset release to idle: init commands, timing and the first draw
    task automatic test_init_and_first_draw();
        int rel;
        int gap;
        bit ok;
        clear_capture();
        rel = cyc;
        RST = 1'b0;
        wait_idle(1000, ok);
        tests_run++; if (!ok) begin tests_failed++; $display("FAIL init_timeout: BUSY still %b", BUSY); end
        model_init();
        model_draw(0, 0);
        tests_run++;
        if (mon_q.size() != 38) begin tests_failed++; $display("FAIL init_count: got %0d pulses want 38", mon_q.size()); end
        if (mon_cyc.size() >= 5) begin
            tests_run++;
            if (mon_cyc[0] - rel != PWR_TICKS + 1) begin
                tests_failed++; $display("FAIL pwr_wait: first strobe %0d cycles after release want %0d", mon_cyc[0] - rel, PWR_TICKS + 1);
            end
            for (int k = 1; k < 5; k++) begin
                gap = (k == 4) ? CMD_TICKS + CLEAR_TICKS + 2 : CMD_TICKS + 2;
                tests_run++;
                if (mon_cyc[k] - mon_cyc[k-1] != gap) begin
                    tests_failed++; $display("FAIL init_gap[%0d]: got %0d want %0d", k, mon_cyc[k] - mon_cyc[k-1], gap);
                end
            end
        end
        for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++) begin
            tests_run++;
            if (mon_q[i] !== exp_q[i]) begin
                tests_failed++; $display("FAIL first_draw[%0d]: got rs=%b data=%h want rs=%b data=%h", i, mon_q[i][8], mon_q[i][7:0], exp_q[i][8], exp_q[i][7:0]);
            end
        end
        tests_run++; if (rw_bad)   begin tests_failed++; $display("FAIL rw_low: got 1 want 0"); end
        tests_run++; if (unstable) begin tests_failed++; $display("FAIL bus_stable: RS/DATA changed during E high"); end
    endtask

    task automatic test_redraw(input int msg, input int cr, input string name);
        bit ok;
        clear_capture();
        MSG_SEL = 2'(msg);
        CREDIT = 7'(cr);
        @(negedge CLK);
        #1;
        tests_run++; if (BUSY !== 1'b1) begin tests_failed++; $display("FAIL %s_busy_rise: got %b want 1", name, BUSY); end
        wait_idle(1000, ok);
        tests_run++; if (!ok) begin tests_failed++; $display("FAIL %s_timeout: BUSY still %b", name, BUSY); end
        model_draw(msg, cr);
        cur_msg = msg;
        cur_cr = cr;
        tests_run++;
        if (mon_q.size() != 34) begin tests_failed++; $display("FAIL %s_count: got %0d pulses want 34", name, mon_q.size()); end
        for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++) begin
            tests_run++;
            if (mon_q[i] !== exp_q[i]) begin
                tests_failed++; $display("FAIL %s[%0d]: got rs=%b data=%h want rs=%b data=%h", name, i, mon_q[i][8], mon_q[i][7:0], exp_q[i][8], exp_q[i][7:0]);
            end
        end
    endtask

    task automatic test_mid_draw();
        bit ok;
        clear_capture();
        MSG_SEL = 2'd2;
        CREDIT = 7'd5;
        repeat (20) @(negedge CLK);
        #1;
        CREDIT = 7'd6;
        repeat (20) @(negedge CLK);
        #1;
        CREDIT = 7'd9;
        wait_idle(2000, ok);
        tests_run++; if (!ok) begin tests_failed++; $display("FAIL mid_timeout: BUSY still %b", BUSY); end
        model_draw(2, 5);
        model_draw(2, 9);
        cur_msg = 2;
        cur_cr = 9;
        tests_run++;
        if (mon_q.size() != 68) begin tests_failed++; $display("FAIL mid_count: got %0d pulses want 68", mon_q.size()); end
        for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++) begin
            tests_run++;
            if (mon_q[i] !== exp_q[i]) begin
                tests_failed++; $display("FAIL mid[%0d]: got rs=%b data=%h want rs=%b data=%h", i, mon_q[i][8], mon_q[i][7:0], exp_q[i][8], exp_q[i][7:0]);
            end
        end
        tests_run++; if (BUSY !== 1'b0) begin tests_failed++; $display("FAIL mid_busy: got %b want 0", BUSY); end
    endtask

    // Random targets; one repeat of the current value must produce no writes at all
    task automatic test_random();
        int msg;
        int cr;
        bit ok;
        for (int it = 0; it < 6; it++) begin
            clear_capture();
            if (it == 2) begin
                msg = cur_msg;
                cr = cur_cr;
            end else begin
                msg = int'($urandom_range(3, 0));
                cr = int'($urandom_range(127, 0));
            end
            MSG_SEL = 2'(msg);
            CREDIT = 7'(cr);
            repeat (3) @(negedge CLK);
            wait_idle(1000, ok);
            tests_run++; if (!ok) begin tests_failed++; $display("FAIL rand%0d_timeout: BUSY still %b", it, BUSY); end
            if (msg != cur_msg || cr != cur_cr) model_draw(msg, cr);
            cur_msg = msg;
            cur_cr = cr;
            tests_run++;
            if (mon_q.size() != exp_q.size()) begin
                tests_failed++; $display("FAIL rand%0d_count: got %0d pulses want %0d", it, mon_q.size(), exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++) begin
                tests_run++;
                if (mon_q[i] !== exp_q[i]) begin
                    tests_failed++; $display("FAIL rand%0d[%0d]: got rs=%b data=%h want rs=%b data=%h", it, i, mon_q[i][8], mon_q[i][7:0], exp_q[i][8], exp_q[i][7:0]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_write();
        int rel;
        bit ok;
        bit seen;
        cur_msg = (cur_msg + 1) % 4;
        cur_cr = 42;
        MSG_SEL = 2'(cur_msg);
        CREDIT = 7'(cur_cr);
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge CLK);
            #1;
            if (LCD_E === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        tests_run++; if (!seen) begin tests_failed++; $display("FAIL rstmid_strobe: no E pulse seen"); end
        RST = 1'b1;
        #1;
        tests_run++; if (LCD_E !== 1'b0) begin tests_failed++; $display("FAIL rstmid_e: got %b want 0", LCD_E); end
        tests_run++; if (BUSY !== 1'b1)  begin tests_failed++; $display("FAIL rstmid_busy: got %b want 1", BUSY); end
        repeat (2) @(negedge CLK);
        #1;
        clear_capture();
        rel = cyc;
        RST = 1'b0;
        wait_idle(1000, ok);
        tests_run++; if (!ok) begin tests_failed++; $display("FAIL rstmid_timeout: BUSY still %b", BUSY); end
        model_init();
        model_draw(cur_msg, cur_cr);
        tests_run++;
        if (mon_q.size() != 38) begin tests_failed++; $display("FAIL rstmid_count: got %0d pulses want 38", mon_q.size()); end
        if (mon_cyc.size() > 0) begin
            tests_run++;
            if (mon_cyc[0] - rel != PWR_TICKS + 1) begin
                tests_failed++; $display("FAIL rstmid_pwr: first strobe %0d cycles after release want %0d", mon_cyc[0] - rel, PWR_TICKS + 1);
            end
        end
        for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++) begin
            tests_run++;
            if (mon_q[i] !== exp_q[i]) begin
                tests_failed++; $display("FAIL rstmid[%0d]: got rs=%b data=%h want rs=%b data=%h", i, mon_q[i][8], mon_q[i][7:0], exp_q[i][8], exp_q[i][7:0]);
            end
        end
        tests_run++; if (unstable) begin tests_failed++; $display("FAIL bus_stable_end: RS/DATA changed during E high"); end
        tests_run++; if (rw_bad)   begin tests_failed++; $display("FAIL rw_low_end: got 1 want 0"); end
    endtask

    initial begin
        test_reset();
        test_init_and_first_draw();
        test_redraw(1, 7, "redraw");
        test_redraw(3, 120, "saturate");
        test_mid_draw();
        test_random();
        test_reset_mid_write();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
